// File: rtl/sigrecord_pkg.sv
// Shared types and default widths for the sigrecord sample recorder.
package sigrecord_pkg;

  localparam int DEF_A_WIDTH = 8;
  localparam int DEF_D_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

endpackage

// File: rtl/sigrecord_ram.sv
// Sample buffer for sigrecord: one write port, one registered read port (latency 1).
// The read register clears on rst and holds its value on cycles without a read.
module record_ram #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem [0:(1<<A_WIDTH)-1];
  logic [D_WIDTH-1:0] rd_data_p1;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // read stage: address in this cycle, data visible after the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_p1 <= '0;
    end else if (rd_en) begin
      rd_data_p1 <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_p1;

endmodule

// File: rtl/sigrecord.sv
// Record/playback sample buffer with strided read-back.
// Define SIGRECORD_LOOP_EN to make playback wrap and run until rst instead of stopping.
module sigrecord
  import sigrecord_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int D_WIDTH = DEF_D_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               rec,
  input  logic               play,
  input  logic [A_WIDTH-1:0] incr,
  input  logic [A_WIDTH-1:0] length,
  input  logic [D_WIDTH-1:0] mic_signal,
  output logic [D_WIDTH-1:0] playback_signal,
  output logic               playback_valid,
  output logic               busy,
  output logic               done
);

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [A_WIDTH:0]   len_lat, rec_len;
  logic [A_WIDTH:0]   len_eff, rd_next;
  logic [A_WIDTH-1:0] incr_eff;
  logic               wr_en, rd_en, start_rec, start_play;
  logic               rec_last, play_last;
  logic               rd_vld_p1, done_p1;

  // length 0 encodes a full 2^A_WIDTH buffer; the extra MSB carries it
  assign len_eff   = {(length == '0), length};
  assign incr_eff  = (incr == '0) ? A_WIDTH'(1) : incr;
  assign rd_next   = {1'b0, rd_ptr} + {1'b0, incr_eff};
  assign rec_last  = ({1'b0, wr_ptr} == (len_lat - 1'b1));
  assign play_last = (rd_next >= rec_len);

`ifdef SIGRECORD_LOOP_EN
  logic [A_WIDTH:0] rd_wrap;
  assign rd_wrap = rd_next - rec_len;
`endif

  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    start_rec  = 1'b0;
    start_play = 1'b0;
    case (state)
      IDLE: begin
        if (rec) begin
          start_rec = 1'b1;
          state_nxt = RECORD;
        end else if (play && (rec_len != '0)) begin
          start_play = 1'b1;
          state_nxt  = PLAY;
        end
      end
      RECORD: begin
        if (en) begin
          wr_en = 1'b1;
          if (rec_last) state_nxt = IDLE;
        end
      end
      PLAY: begin
        if (en) begin
          rd_en = 1'b1;
`ifndef SIGRECORD_LOOP_EN
          if (play_last) state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // control stage: pointers, lengths and the one-cycle-late valid/done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      len_lat   <= '0;
      rec_len   <= '0;
      rd_vld_p1 <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= rd_en;
      done_p1   <= 1'b0;
      if (start_rec) begin
        wr_ptr  <= '0;
        len_lat <= len_eff;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (rec_last) begin
          rec_len <= len_lat;
          done_p1 <= 1'b1;
        end
      end
      if (start_play) begin
        rd_ptr <= '0;
      end else if (rd_en) begin
        if (!play_last) begin
          rd_ptr <= rd_next[A_WIDTH-1:0];
        end else begin
`ifdef SIGRECORD_LOOP_EN
          rd_ptr <= rd_wrap[A_WIDTH-1:0];
`else
          done_p1 <= 1'b1;
`endif
        end
      end
    end
  end

  record_ram #(
    .A_WIDTH(A_WIDTH),
    .D_WIDTH(D_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(mic_signal),
    .rd_en  (rd_en),
    .rd_addr(rd_ptr),
    .rd_data(playback_signal)
  );

  assign playback_valid = rd_vld_p1;
  assign done           = done_p1;
  assign busy           = (state != IDLE);

endmodule
